mmf_drive: RTL and testbench

Current-waveform generator that produces the 8-bit `current` stimulus consumed by the `mmf` block inside `tt_um_mmf_mtchun`; it is the drive end of that interface. It accepts one drive request at a time over a valid/ready handshake. It ramps `current` from its present value toward a requested target in fixed steps, holds it there for a programmable dwell, then optionally ramps it back to zero. Completion is signalled with a one-cycle `done` pulse.

---
 rtl/mmf_drive_if.sv | 24 ++
 rtl/mmf_drive.sv | 139 +++++++++++++
 tb/tb_mmf_drive.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmf_drive_if.sv
// Drive-request channel into mmf_drive. A request transfers on a rising edge
// where req_valid && req_ready; the master holds target/step/dwell/return_en stable while req_valid is high.
interface mmf_drive_if #(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int DWELL_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   target;
  logic [STEP_W-1:0]  step;
  logic [DWELL_W-1:0] dwell;
  logic               return_en;

  modport master (
    output req_valid, target, step, dwell, return_en,
    input  req_ready
  );

  modport slave (
    input  req_valid, target, step, dwell, return_en,
    output req_ready
  );
endinterface

// File: rtl/mmf_drive.sv
// Current-waveform generator for the mmf block: ramps `current` to a target,
// dwells, optionally ramps back to zero, then pulses `done`.
module mmf_drive #(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int DWELL_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  mmf_drive_if.slave       req,
  input  logic             abort,
  output logic [WIDTH-1:0] current,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_DWELL  = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   cur_q;
  logic [WIDTH-1:0]   tgt_q;
  logic [STEP_W-1:0]  step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               ret_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               done_q;
  logic               busy_q;
  logic               ready_q;

  // Distances are taken one bit wider than the datapath so a large step never wraps.
  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   tgt_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   ramp_diff;
  logic             ramp_up;
  logic [WIDTH-1:0] ramp_next;
  logic [WIDTH-1:0] ret_next;

  assign cur_ext  = {1'b0, cur_q};
  assign tgt_ext  = {1'b0, tgt_q};
  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step_q};

  always_comb begin
    ramp_up   = (tgt_ext >= cur_ext);
    ramp_diff = ramp_up ? (tgt_ext - cur_ext) : (cur_ext - tgt_ext);
    ramp_next = cur_q;
    if (ramp_diff <= step_ext) begin
      ramp_next = tgt_q;
    end else if (ramp_up) begin
      ramp_next = cur_q + step_ext[WIDTH-1:0];
    end else begin
      ramp_next = cur_q - step_ext[WIDTH-1:0];
    end
    ret_next = (cur_ext <= step_ext) ? '0 : (cur_q - step_ext[WIDTH-1:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      ret_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req.req_valid && ready_q) begin
            tgt_q   <= req.target;
            step_q  <= (req.step == '0) ? STEP_W'(1) : req.step;
            dwell_q <= req.dwell;
            ret_q   <= req.return_en;
            state   <= S_RAMP;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        S_RAMP: begin
          // Abort takes priority over the ramp step, including the final one.
          if (abort) begin
            state <= S_RETURN;
          end else begin
            cur_q <= ramp_next;
            if (ramp_next == tgt_q) begin
              state <= S_DWELL;
              cnt_q <= dwell_q;
            end
          end
        end
        S_DWELL: begin
          if (abort) begin
            state <= S_RETURN;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else if (ret_q) begin
            state <= S_RETURN;
          end else begin
            state   <= S_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        S_RETURN: begin
          cur_q <= ret_next;
          if (ret_next == '0) begin
            state   <= S_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign current       = cur_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mmf_drive.sv
// Bench for mmf_drive: table of requests checked by a per-edge scoreboard,
// followed by hand-written abort, reset and handshake sequences.
module tb_mmf_drive;

  logic       clk;
  logic       reset_n;
  logic       abort;
  logic [7:0] current;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  mmf_drive_if #(.WIDTH(8), .STEP_W(4), .DWELL_W(8)) rq ();

  mmf_drive #(.WIDTH(8), .STEP_W(4), .DWELL_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (rq.slave),
    .abort     (abort),
    .current   (current),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int busy_cnt;
  int model_cur;
  logic [8:0] exp_q[$];   // {done, current} expected after each edge
  logic [7:0] obs_q[$];
  logic [8:0] sb_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      check("sb_current", {24'd0, current}, {24'd0, sb_e[7:0]});
      check("sb_done", {31'd0, done}, {31'd0, sb_e[8]});
      check("sb_busy", {31'd0, busy}, {31'd0, ~sb_e[8]});
      if (busy) busy_cnt++;
      obs_q.push_back(current);
    end
  end

  // Expected current after every edge from acceptance to the done cycle.
  task automatic push_model(input logic [7:0] tgt, input logic [3:0] stp, input logic [7:0] dw, input logic ret);
    int cur, s, t, d, n;
    s = (stp == 4'd0) ? 1 : int'(stp);
    t = int'(tgt);
    cur = model_cur;
    exp_q.push_back({1'b0, 8'(cur)});
    do begin
      d = (t > cur) ? (t - cur) : (cur - t);
      if (d <= s) cur = t;
      else if (t > cur) cur = cur + s;
      else cur = cur - s;
      exp_q.push_back({1'b0, 8'(cur)});
    end while (cur != t);
    for (int i = 0; i <= int'(dw); i++) exp_q.push_back({1'b0, 8'(t)});
    if (ret) begin
      do begin
        cur = (cur <= s) ? 0 : (cur - s);
        exp_q.push_back({1'b0, 8'(cur)});
      end while (cur != 0);
    end
    n = exp_q.size();
    exp_q[n-1][8] = 1'b1;
    model_cur = cur;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int k;
    k = 0;
    while (!rq.req_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!rq.req_ready) check("wait_ready", 32'd0, 32'd1);
  endtask

  task automatic set_fields(input logic [7:0] tgt, input logic [3:0] stp, input logic [7:0] dw, input logic ret);
    rq.target    = tgt;
    rq.step      = stp;
    rq.dwell     = dw;
    rq.return_en = ret;
  endtask

  task automatic drive_sb(input logic [7:0] tgt, input logic [3:0] stp, input logic [7:0] dw, input logic ret);
    @(negedge clk);
    wait_ready();
    set_fields(tgt, stp, dw, ret);
    rq.req_valid = 1'b1;
    busy_cnt = 0;
    push_model(tgt, stp, dw, ret);
    @(posedge clk);
    @(negedge clk);
    rq.req_valid = 1'b0;
  endtask

  task automatic drive_hand(input logic [7:0] tgt, input logic [3:0] stp, input logic [7:0] dw, input logic ret);
    @(negedge clk);
    wait_ready();
    set_fields(tgt, stp, dw, ret);
    rq.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rq.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic wait_cur(input logic [7:0] v, input string nm);
    int k;
    k = 0;
    while (current !== v && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(nm, {24'd0, current}, {24'd0, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] tgt;
    logic [3:0] stp;
    logic [7:0] dw;
    logic       ret;
    logic [7:0] exp_final;
    int         exp_busy;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] v0_seq[10] = '{8'd0, 8'd4, 8'd8, 8'd10, 8'd10, 8'd10, 8'd10, 8'd6, 8'd2, 8'd0};
  logic [7:0] hs_cur[9]  = '{8'd0, 8'd10, 8'd20, 8'd20, 8'd10, 8'd0, 8'd0, 8'd5, 8'd5};
  logic       hs_rdy[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] ab_seq[4]  = '{8'd30, 8'd20, 8'd10, 8'd0};

  initial begin
    vecs[0] = '{8'd10,  4'd4,  8'd2, 1'b1, 8'd0,   9};
    vecs[1] = '{8'd200, 4'd15, 8'd0, 1'b0, 8'd200, 15};
    vecs[2] = '{8'd50,  4'd0,  8'd0, 1'b0, 8'd50,  151};
    vecs[3] = '{8'd0,   4'd7,  8'd3, 1'b1, 8'd0,   13};
    vecs[4] = '{8'd0,   4'd5,  8'd0, 1'b1, 8'd0,   3};
    vecs[5] = '{8'd255, 4'd15, 8'd1, 1'b1, 8'd0,   36};

    reset_n      = 1'b0;
    abort        = 1'b0;
    rq.req_valid = 1'b0;
    set_fields(8'd0, 4'd0, 8'd0, 1'b0);
    model_cur    = 0;
    busy_cnt     = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_current", {24'd0, current}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, rq.req_ready}, 32'd1);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      obs_q.delete();
      drive_sb(vecs[i].tgt, vecs[i].stp, vecs[i].dw, vecs[i].ret);
      wait_drain();
      check($sformatf("vec%0d_final", i), {24'd0, current}, {24'd0, vecs[i].exp_final});
      check($sformatf("vec%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
      if (i == 0) begin
        check("v0_seq_len", obs_q.size(), 10);
        for (int j = 0; j < 10 && j < obs_q.size(); j++)
          check($sformatf("v0_seq[%0d]", j), {24'd0, obs_q[j]}, {24'd0, v0_seq[j]});
      end
    end

    // Asynchronous reset in the middle of a ramp.
    drive_hand(8'd100, 4'd20, 8'd0, 1'b0);
    wait_cur(8'd60, "arst_reach60");
    #1 reset_n = 1'b0;
    #1;
    check("arst_current", {24'd0, current}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_ready", {31'd0, rq.req_ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    #1 reset_n = 1'b1;

    // Abort during RAMP with return_en = 0 still returns to zero.
    drive_hand(8'd100, 4'd10, 8'd5, 1'b0);
    wait_cur(8'd40, "abort_reach40");
    abort = 1'b1;
    tick();
    check("abort_hold", {24'd0, current}, 32'd40);
    check("abort_state", {30'd0, state_dbg}, 32'd3);
    @(negedge clk);
    abort = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("abort_ret[%0d]", j), {24'd0, current}, {24'd0, ab_seq[j]});
      check($sformatf("abort_done[%0d]", j), {31'd0, done}, {31'd0, (j == 3)});
    end

    // Abort in IDLE has no effect.
    @(negedge clk);
    abort = 1'b1;
    tick();
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    check("idle_abort_state", {30'd0, state_dbg}, 32'd0);
    check("idle_abort_ready", {31'd0, rq.req_ready}, 32'd1);
    @(negedge clk);
    abort = 1'b0;

    // Abort on the edge that would make the final ramp step.
    drive_hand(8'd30, 4'd10, 8'd0, 1'b1);
    wait_cur(8'd20, "final_abort_reach20");
    abort = 1'b1;
    tick();
    check("final_abort_hold", {24'd0, current}, 32'd20);
    check("final_abort_state", {30'd0, state_dbg}, 32'd3);
    @(negedge clk);
    abort = 1'b0;
    tick();
    check("final_abort_ret1", {24'd0, current}, 32'd10);
    tick();
    check("final_abort_ret0", {24'd0, current}, 32'd0);
    check("final_abort_done", {31'd0, done}, 32'd1);

    // req_valid held high: fields changed while busy must not be latched,
    // and the second request is taken in the done cycle.
    @(negedge clk);
    set_fields(8'd20, 4'd10, 8'd0, 1'b1);
    rq.req_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      tick();
      check($sformatf("hs_cur[%0d]", j), {24'd0, current}, {24'd0, hs_cur[j]});
      check($sformatf("hs_ready[%0d]", j), {31'd0, rq.req_ready}, {31'd0, hs_rdy[j]});
      check($sformatf("hs_done[%0d]", j), {31'd0, done}, {31'd0, hs_rdy[j]});
      if (j == 1) begin
        @(negedge clk);
        set_fields(8'd5, 4'd5, 8'd0, 1'b0);
      end
    end
    @(negedge clk);
    rq.req_valid = 1'b0;
    tick();
    check("hs_idle_done", {31'd0, done}, 32'd0);
    check("hs_idle_busy", {31'd0, busy}, 32'd0);
    check("hs_idle_hold", {24'd0, current}, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
